// File: rtl/bram_rmw_sequencer_pkg.sv
// bram_rmw_pkg: state encoding and timing constants for the BRAM read-modify-write sequencer
package bram_rmw_pkg;
    localparam int STATE_WIDTH     = 3;
    localparam int CYCLES_PER_WORD = 5;
    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_VERIFY  = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6
    } state_t;
endpackage

// File: rtl/bram_rmw_sequencer_if.sv
// bram_rmw_sequencer_if: control, status and BRAM port A bundle; BRAM_RMW_FIRST_FAIL_EN adds first-fail reporting
interface bram_rmw_sequencer_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
);
    logic                     I_START;
    logic [ADDRESS_WIDTH-1:0] I_BASE_ADDRESS;
    logic [ADDRESS_WIDTH-1:0] I_COUNT;
    logic [DATA_WIDTH-1:0]    I_OPERAND;
    logic [DATA_WIDTH-1:0]    I_BRAM_DATA;
    logic [DATA_WIDTH-1:0]    O_BRAM_DATA;
    logic [ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS;
    logic                     O_BRAM_WRITE_ENABLE;
    logic                     O_BUSY;
    logic                     O_DONE;
    logic                     O_PASS;
    logic [ADDRESS_WIDTH-1:0] O_ERROR_COUNT;
    logic [DATA_WIDTH-1:0]    O_LAST_DATA;
`ifdef BRAM_RMW_FIRST_FAIL_EN
    logic [ADDRESS_WIDTH-1:0] O_FIRST_FAIL_ADDRESS;
    logic                     O_FIRST_FAIL_VALID;
`endif
    // the sequencer side: drives BRAM port A and status
    modport master (
        input  I_START, I_BASE_ADDRESS, I_COUNT, I_OPERAND, I_BRAM_DATA,
        output O_BRAM_DATA, O_BRAM_ADDRESS, O_BRAM_WRITE_ENABLE, O_BUSY, O_DONE, O_PASS,
               O_ERROR_COUNT, O_LAST_DATA
`ifdef BRAM_RMW_FIRST_FAIL_EN
        , output O_FIRST_FAIL_ADDRESS, O_FIRST_FAIL_VALID
`endif
    );
    // the environment side: issues requests, supplies BRAM read data
    modport slave (
        output I_START, I_BASE_ADDRESS, I_COUNT, I_OPERAND, I_BRAM_DATA,
        input  O_BRAM_DATA, O_BRAM_ADDRESS, O_BRAM_WRITE_ENABLE, O_BUSY, O_DONE, O_PASS,
               O_ERROR_COUNT, O_LAST_DATA
`ifdef BRAM_RMW_FIRST_FAIL_EN
        , input O_FIRST_FAIL_ADDRESS, O_FIRST_FAIL_VALID
`endif
    );
endinterface

// File: rtl/bram_rmw_sequencer_saturating_counter.sv
// saturating_counter: clearable up-counter that sticks at all-ones
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             I_CLK,
    input  logic             I_NRESET,
    input  logic             clear_i,
    input  logic             increment_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    // clear wins over increment; increment is dropped once all-ones is reached
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) count_q <= '0;
        else if (clear_i) count_q <= '0;
        else if (increment_i && !(&count_q)) count_q <= count_q + WIDTH'(1);
    end
    assign count_o = count_q;
endmodule

// File: rtl/bram_rmw_sequencer.sv
// bram_rmw_sequencer: read/add/write/re-read verify pass over a BRAM range; BRAM_RMW_FIRST_FAIL_EN adds first-fail address capture
module bram_rmw_sequencer
    import bram_rmw_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                 I_CLK,
    input  logic                 I_NRESET,
    bram_rmw_sequencer_if.master bus
);
    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] base_q, count_q, index_q, error_count;
    logic [DATA_WIDTH-1:0]    operand_q, expected_q, last_q;
    logic                     accept, mismatch, last_word;

    assign accept    = (state_q == S_IDLE || state_q == S_DONE) && bus.I_START;
    assign mismatch  = state_q == S_CHECK && bus.I_BRAM_DATA != expected_q;
    assign last_word = index_q == count_q - ADDRESS_WIDTH'(1);

    // state register
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // next state: five fixed steps per word, zero-length passes finish immediately
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.I_START) state_d = bus.I_COUNT == '0 ? S_DONE : S_READ;
            S_READ:         state_d = S_CAPTURE;
            S_CAPTURE:      state_d = S_WRITE;
            S_WRITE:        state_d = S_VERIFY;
            S_VERIFY:       state_d = S_CHECK;
            S_CHECK:        state_d = last_word ? S_DONE : S_READ;
            default:        state_d = S_IDLE;
        endcase
    end

    // pass parameters, the per-word expected value and the displayed word
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            base_q     <= '0;
            count_q    <= '0;
            index_q    <= '0;
            operand_q  <= '0;
            expected_q <= '0;
            last_q     <= '0;
        end else begin
            if (accept) begin
                base_q    <= bus.I_BASE_ADDRESS;
                count_q   <= bus.I_COUNT;
                operand_q <= bus.I_OPERAND;
                index_q   <= '0;
            end
            if (state_q == S_CAPTURE) expected_q <= bus.I_BRAM_DATA + operand_q;
            if (state_q == S_CHECK) begin
                last_q <= bus.I_BRAM_DATA;
                if (!last_word) index_q <= index_q + ADDRESS_WIDTH'(1);
            end
        end
    end

    saturating_counter #(.WIDTH(ADDRESS_WIDTH)) u_error_count (
        .I_CLK       (I_CLK),
        .I_NRESET    (I_NRESET),
        .clear_i     (accept),
        .increment_i (mismatch),
        .count_o     (error_count)
    );

`ifdef BRAM_RMW_FIRST_FAIL_EN
    logic [ADDRESS_WIDTH-1:0] first_fail_address_q;
    logic                     first_fail_valid_q;
    // remember only the first mismatching address of the current pass
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            first_fail_address_q <= '0;
            first_fail_valid_q   <= 1'b0;
        end else if (accept) begin
            first_fail_address_q <= '0;
            first_fail_valid_q   <= 1'b0;
        end else if (mismatch && !first_fail_valid_q) begin
            first_fail_address_q <= bus.O_BRAM_ADDRESS;
            first_fail_valid_q   <= 1'b1;
        end
    end
    assign bus.O_FIRST_FAIL_ADDRESS = first_fail_address_q;
    assign bus.O_FIRST_FAIL_VALID   = first_fail_valid_q;
`endif

    assign bus.O_BRAM_ADDRESS      = base_q + index_q;
    assign bus.O_BRAM_DATA         = expected_q;
    assign bus.O_BRAM_WRITE_ENABLE = state_q == S_WRITE;
    assign bus.O_BUSY              = state_q inside {S_READ, S_CAPTURE, S_WRITE, S_VERIFY, S_CHECK};
    assign bus.O_DONE              = state_q == S_DONE;
    assign bus.O_PASS              = state_q == S_DONE && error_count == '0;
    assign bus.O_ERROR_COUNT       = error_count;
    assign bus.O_LAST_DATA         = last_q;
endmodule

// File: tb/tb_bram_rmw_sequencer.sv
// tb_bram_rmw_sequencer: directed and random passes against a word-level reference of memory contents
module tb_bram_rmw_sequencer;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        init_en = 1'b0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic        force_dead = 1'b0;
    logic [15:0] rdata;
    logic [15:0] mem [65536];
    logic [15:0] ref_mem [65536];
    int          we_cnt = 0;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    bram_rmw_sequencer_if bus ();
    bram_rmw_sequencer dut (.I_CLK(clk), .I_NRESET(nrst), .bus(bus));

    assign bus.I_BRAM_DATA = force_dead ? 16'hDEAD : rdata;

    // synchronous read-first BRAM port A with tb-side init and preload access
    always @(posedge clk) begin
        rdata <= mem[bus.O_BRAM_ADDRESS];
        if (init_en) begin
            for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        end else if (pl_en) begin
            mem[pl_addr] = pl_data;
        end else if (bus.O_BRAM_WRITE_ENABLE) begin
            mem[bus.O_BRAM_ADDRESS] = bus.O_BRAM_DATA;
            we_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        tick();
        pl_en = 1'b0;
    endtask

    // one pass; corrupt >= 0 replaces the CHECK read of that word with 0xDEAD
    task automatic run(input logic [15:0] base, input logic [15:0] cnt, input logic [15:0] op,
                       input int corrupt, input bit poke);
        int          edges;
        int          errs;
        logic [15:0] a;
        logic [15:0] last;
        bus.I_BASE_ADDRESS = base;
        bus.I_COUNT = cnt;
        bus.I_OPERAND = op;
        bus.I_START = 1'b1;
        tick();
        bus.I_START = 1'b0;
        edges = 1;
        check("busy_after_start", 32'(bus.O_BUSY), 32'(cnt != 0));
        while (!bus.O_DONE && edges < 2000) begin
            tick();
            edges++;
            bus.I_START = poke && edges == 7;
            force_dead = corrupt >= 0 && edges == 5 * corrupt + 5;
        end
        bus.I_START = 1'b0;
        force_dead = 1'b0;
        errs = 0;
        last = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 16'(i);
            ref_mem[a] = ref_mem[a] + op;
            check("mem_word", 32'(mem[a]), 32'(ref_mem[a]));
            if (i == corrupt) errs++;
            last = i == corrupt ? 16'hDEAD : ref_mem[a];
        end
        check("done_latency", 32'(edges), 32'(5 * int'(cnt) + 1));
        check("done", 32'(bus.O_DONE), 32'd1);
        check("busy_at_done", 32'(bus.O_BUSY), 32'd0);
        check("pass", 32'(bus.O_PASS), 32'(errs == 0));
        check("error_count", 32'(bus.O_ERROR_COUNT), 32'(errs));
        if (cnt != 0) check("last_data", 32'(bus.O_LAST_DATA), 32'(last));
`ifdef BRAM_RMW_FIRST_FAIL_EN
        check("first_fail_valid", 32'(bus.O_FIRST_FAIL_VALID), 32'(errs != 0));
        if (errs != 0) check("first_fail_addr", 32'(bus.O_FIRST_FAIL_ADDRESS), 32'(base + 16'(corrupt)));
`endif
    endtask

    initial begin
        int          w0;
        logic [15:0] rb;
        logic [15:0] rc;
        bus.I_START = 1'b0;
        bus.I_BASE_ADDRESS = '0;
        bus.I_COUNT = '0;
        bus.I_OPERAND = '0;
        #2 nrst = 1'b0;
        #1;
        check("rst_done", 32'(bus.O_DONE), 32'd0);
        check("rst_busy", 32'(bus.O_BUSY), 32'd0);
        check("rst_we", 32'(bus.O_BRAM_WRITE_ENABLE), 32'd0);
        check("rst_err", 32'(bus.O_ERROR_COUNT), 32'd0);
        init_en = 1'b1;
        tick();
        init_en = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        nrst = 1'b1;
        tick();

        preload(16'h0000, 16'h0001);
        preload(16'h0001, 16'h00FF);
        preload(16'h0002, 16'h7FFF);
        preload(16'h0003, 16'hFFFF);
        run(16'h0000, 16'd4, 16'h0001, -1, 1'b0);
        check("carry_word2", 32'(mem[2]), 32'h8000);
        check("wrap_word3", 32'(mem[3]), 32'h0000);

        w0 = we_cnt;
        run(16'h0010, 16'd0, 16'h1234, -1, 1'b0);
        check("count0_no_write", 32'(we_cnt), 32'(w0));

        run(16'hFFFE, 16'd3, 16'h0010, -1, 1'b0);

        run(16'h0100, 16'd4, 16'(16'h0F00 + $urandom_range(0, 255)), 1, 1'b1);
        run(16'h0100, 16'd4, 16'hFFFF, -1, 1'b0);

        bus.I_BASE_ADDRESS = 16'h0200;
        bus.I_COUNT = 16'd4;
        bus.I_OPERAND = 16'h0005;
        bus.I_START = 1'b1;
        tick();
        bus.I_START = 1'b0;
        repeat (7) tick();
        check("in_write_word2", 32'(bus.O_BRAM_WRITE_ENABLE), 32'd1);
        nrst = 1'b0;
        #1;
        check("abort_we", 32'(bus.O_BRAM_WRITE_ENABLE), 32'd0);
        check("abort_busy", 32'(bus.O_BUSY), 32'd0);
        check("abort_done", 32'(bus.O_DONE), 32'd0);
        check("abort_addr", 32'(bus.O_BRAM_ADDRESS), 32'd0);
        check("abort_wdata", 32'(bus.O_BRAM_DATA), 32'd0);
        check("abort_last", 32'(bus.O_LAST_DATA), 32'd0);
        tick();
        nrst = 1'b1;
        repeat (2) tick();
        ref_mem[16'h0200] = ref_mem[16'h0200] + 16'h0005;
        for (int i = 0; i < 4; i++) check("abort_mem", 32'(mem[16'h0200 + 16'(i)]), 32'(ref_mem[16'h0200 + 16'(i)]));

        for (int n = 0; n < 6; n++) begin
            rb = 16'($urandom);
            rc = 16'($urandom_range(1, 8));
            run(rb, rc, 16'($urandom), $urandom_range(0, 1) == 1 ? int'($urandom_range(0, int'(rc) - 1)) : -1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
